// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: central stall/flush controller for the five-stage AXI pipeline.
// Tracks outstanding instruction/data bus transactions and sequences MEM-stage
// exceptions through a drain phase, because in-flight AXI transactions cannot
// be aborted.
// Optional feature: define CTRL_WDOG_EN to add a drain watchdog that forces a
// flush after WDOG_LIMIT drain cycles and pulses wdog_err.
module pipe_flush_ctrl #(
    parameter int CNT_W      = 2,
    parameter int WDOG_LIMIT = 255
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        ibus_issue,
    input  logic        ibus_ack,
    input  logic        dbus_issue,
    input  logic        dbus_ack,
    input  logic        dbus_req,
    input  logic        exe_stallreq,
    input  logic        excp_req,
    input  logic [31:0] excp_pc,
    output logic [4:0]  stall,
    output logic        mem_stop_wb,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        i_issue_en,
    output logic        d_issue_en,
    output logic        ack_drop,
    output logic [1:0]  ctrl_state,
    output logic        wdog_err
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_RSVD  = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] i_cnt, d_cnt;
    logic [CNT_W-1:0] i_nxt, d_nxt;
    logic             load_pc;
    logic             issue_ok;
    logic             drop_win;
    logic             wdog_hit;
    logic             cnt_idle_nxt;

    // Saturating outstanding-count update: acks at zero and issues at max
    // (without a matching ack) are ignored.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic iss, input logic ack);
        logic [CNT_W-1:0] r;
        r = c;
        if (iss && !ack) begin
            if (c != CNT_MAX) r = c + CNT_W'(1);
        end else if (ack && !iss) begin
            if (c != '0) r = c - CNT_W'(1);
        end else if (ack && iss) begin
            if (c == '0) r = CNT_W'(1);
        end
        return r;
    endfunction

    // Next outstanding counts, used both for the counter update and for
    // deciding when the drain is complete.
    always_comb begin
        i_nxt        = cnt_next(i_cnt, ibus_issue, ibus_ack);
        d_nxt        = cnt_next(d_cnt, dbus_issue, dbus_ack);
        cnt_idle_nxt = (i_nxt == '0) && (d_nxt == '0);
    end

`ifdef CTRL_WDOG_EN
    logic [7:0] wdog_cnt;
    logic       wdog_q;

    assign wdog_hit = (state == S_DRAIN) && (wdog_cnt == 8'(WDOG_LIMIT - 1));
    assign wdog_err = wdog_q;

    // Drain-cycle counter; held at zero outside DRAIN so it starts clean on entry.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            wdog_cnt <= (state == S_DRAIN) ? wdog_cnt + 8'd1 : 8'd0;
            wdog_q   <= wdog_hit;
        end
    end
`else
    logic wdog_unused;
    assign wdog_unused = (WDOG_LIMIT != 0);
    assign wdog_hit    = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    // Outstanding counters; a watchdog timeout abandons whatever is in flight.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            i_cnt <= '0;
            d_cnt <= '0;
        end else if (wdog_hit) begin
            i_cnt <= '0;
            d_cnt <= '0;
        end else begin
            i_cnt <= i_nxt;
            d_cnt <= d_nxt;
        end
    end

    // State and redirect-PC registers.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state    <= S_RUN;
            flush_pc <= 32'h0;
        end else begin
            state <= state_nxt;
            if (load_pc) flush_pc <= excp_pc;
        end
    end

    // Next-state and combinational stall/ack-drop decode.
    always_comb begin
        state_nxt   = state;
        stall       = 5'b00000;
        mem_stop_wb = 1'b0;
        load_pc     = 1'b0;
        issue_ok    = 1'b0;
        drop_win    = 1'b0;
        case (state)
            S_RUN: begin
                issue_ok    = ~excp_req;
                mem_stop_wb = dbus_req & ~dbus_ack;
                if (excp_req) begin
                    stall     = 5'b11111;
                    drop_win  = 1'b1;
                    load_pc   = 1'b1;
                    state_nxt = cnt_idle_nxt ? S_FLUSH : S_DRAIN;
                end else if (dbus_req && !dbus_ack) begin
                    stall = 5'b01111;
                end else if (exe_stallreq) begin
                    stall = 5'b00111;
                end else if ((i_cnt != '0) && !ibus_ack) begin
                    stall = 5'b00001;
                end
            end
            S_DRAIN: begin
                stall       = 5'b11111;
                mem_stop_wb = 1'b1;
                drop_win    = 1'b1;
                if (wdog_hit || cnt_idle_nxt) state_nxt = S_FLUSH;
            end
            S_FLUSH: state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    assign flush      = (state == S_FLUSH);
    assign ctrl_state = state;
    assign i_issue_en = issue_ok & (i_cnt != CNT_MAX);
    assign d_issue_en = issue_ok & (d_cnt != CNT_MAX);
    assign ack_drop   = drop_win & (ibus_ack | dbus_ack);

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Bench for pipe_flush_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_pipe_flush_ctrl;

    localparam int CNT_W = 2;
    localparam int LIMIT = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef CTRL_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        ibus_issue, ibus_ack, dbus_issue, dbus_ack, dbus_req;
    logic        exe_stallreq, excp_req;
    logic [31:0] excp_pc;
    logic [4:0]  stall;
    logic        mem_stop_wb, flush, i_issue_en, d_issue_en, ack_drop, wdog_err;
    logic [31:0] flush_pc;
    logic [1:0]  ctrl_state;

    pipe_flush_ctrl #(.CNT_W(CNT_W), .WDOG_LIMIT(LIMIT)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .ibus_issue  (ibus_issue),
        .ibus_ack    (ibus_ack),
        .dbus_issue  (dbus_issue),
        .dbus_ack    (dbus_ack),
        .dbus_req    (dbus_req),
        .exe_stallreq(exe_stallreq),
        .excp_req    (excp_req),
        .excp_pc     (excp_pc),
        .stall       (stall),
        .mem_stop_wb (mem_stop_wb),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .i_issue_en  (i_issue_en),
        .d_issue_en  (d_issue_en),
        .ack_drop    (ack_drop),
        .ctrl_state  (ctrl_state),
        .wdog_err    (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: phase 0 run, 2 drain, 3 flush
    int          m_st, m_i, m_d, m_dc;
    logic [31:0] m_pc;
    bit          m_wd;
    int          n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_i = 0; m_d = 0; m_dc = 0; m_pc = 32'h0; m_wd = 1'b0;
    endtask

    task automatic check_outs();
        bit         run, ex;
        logic [4:0] es;
        logic       emsw;
        run = (m_st == 0);
        ex  = run && excp_req;
        es  = 5'b00000;
        emsw = 1'b0;
        if (m_st == 2) begin
            es = 5'b11111; emsw = 1'b1;
        end else if (run) begin
            emsw = dbus_req && !dbus_ack;
            if (ex)                        es = 5'b11111;
            else if (dbus_req && !dbus_ack) es = 5'b01111;
            else if (exe_stallreq)         es = 5'b00111;
            else if (m_i != 0 && !ibus_ack) es = 5'b00001;
        end
        chk("stall", 32'(stall), 32'(es));
        if (!ex) chk("mem_stop_wb", 32'(mem_stop_wb), 32'(emsw));
        chk("flush", 32'(flush), 32'(m_st == 3));
        chk("flush_pc", flush_pc, m_pc);
        chk("i_issue_en", 32'(i_issue_en), 32'(run && !excp_req && m_i < MAXC));
        chk("d_issue_en", 32'(d_issue_en), 32'(run && !excp_req && m_d < MAXC));
        chk("ack_drop", 32'(ack_drop), 32'((ibus_ack || dbus_ack) && (m_st == 2 || ex)));
        chk("ctrl_state", 32'(ctrl_state), 32'(m_st));
        chk("wdog_err", 32'(wdog_err), 32'(m_wd));
    endtask

    task automatic model_step();
        int ni, nd, ns;
        bit nwd;
        ni = m_i + int'(ibus_issue);
        if (ibus_ack && m_i > 0) ni--;
        if (ni > MAXC) ni = MAXC;
        nd = m_d + int'(dbus_issue);
        if (dbus_ack && m_d > 0) nd--;
        if (nd > MAXC) nd = MAXC;
        ns  = m_st;
        nwd = 1'b0;
        case (m_st)
            0: if (excp_req) begin
                   m_pc = excp_pc;
                   m_dc = 0;
                   ns = (ni == 0 && nd == 0) ? 3 : 2;
               end
            2: begin
                   m_dc++;
                   if (WD_EN && m_dc == LIMIT) begin
                       ni = 0; nd = 0; ns = 3; nwd = 1'b1;
                   end else if (ni == 0 && nd == 0) begin
                       ns = 3;
                   end
               end
            default: ns = 0;
        endcase
        m_i = ni; m_d = nd; m_st = ns; m_wd = nwd;
    endtask

    task automatic drive(input bit ii, input bit ia, input bit di, input bit da,
                         input bit dr, input bit ex, input bit er, input logic [31:0] pc);
        ibus_issue = ii; ibus_ack = ia; dbus_issue = di; dbus_ack = da;
        dbus_req = dr; exe_stallreq = ex; excp_req = er; excp_pc = pc;
    endtask

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_outs();
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        model_reset();
        #12;
        do_reset();

        // data wait: three stalled cycles then ack
        drive(0, 0, 0, 0, 1, 0, 0, 32'h0); cyc(3);
        drive(0, 0, 0, 1, 1, 0, 0, 32'h0); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0); cyc();

        // exception with nothing outstanding
        drive(0, 0, 0, 0, 0, 0, 1, 32'hBFC00380); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0); cyc(2);

        // exception with one fetch and one data access in flight
        drive(1, 0, 1, 0, 0, 0, 0, 32'h0); cyc();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678); cyc();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF); cyc();
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0); cyc(2);
        drive(0, 0, 0, 1, 0, 0, 0, 32'h0); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0); cyc(2);

        // fetch counter saturation
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0); cyc(4);
        drive(1, 1, 0, 0, 0, 0, 0, 32'h0); cyc();
        drive(0, 1, 0, 0, 0, 0, 0, 32'h0); cyc(4);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0); cyc();

        // data stall wins over EXE stall
        drive(0, 0, 0, 0, 1, 1, 0, 32'h0); cyc();
        drive(0, 0, 0, 1, 1, 1, 0, 32'h0); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0); cyc();

        // drain with no ack: watchdog if built in, otherwise waits for the ack
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0); cyc();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h0000_0180); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0); cyc(7);
        drive(0, 1, 0, 0, 0, 0, 0, 32'h0); cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0); cyc(3);

        // asynchronous reset in the middle of a drain
        drive(0, 0, 1, 0, 0, 0, 0, 32'h0); cyc();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hAAAA_5555); cyc();
        drive(0, 0, 0, 0, 1, 0, 0, 32'h0); cyc();
        do_reset();
        cyc(2);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0, $urandom);
            cyc();
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
